// File: rtl/arb_pkg.sv
// Shared types and the round-robin winner search for the 8-way arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning ptr+1, ptr+2, ... ptr+8 (wrapping).
  // ptr itself is the last candidate; callers that must skip the current
  // holder mask its bit out of req before calling.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            p;
    logic [IDX_W-1:0] cand;
    p.found = 1'b0;
    p.idx   = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/decoder3x8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3x8 (
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign out[gi] = en && (in == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with grant locking and a bounded
// contended hold time. Grant is decoded from registers only.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   gnt_idx_reg, gnt_idx_next;
  logic               gnt_valid_reg, gnt_valid_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;

  logic [NUM_REQ-1:0] others;
  pick_t              pick_all;
  pick_t              pick_oth;

  // Requests other than the current holder; used at handover/preemption.
  assign others   = req & ~(NUM_REQ'(1) << gnt_idx_reg);
  assign pick_all = rr_pick(req, ptr_reg);
  assign pick_oth = rr_pick(others, ptr_reg);

  // State register with synchronous active-low reset; ptr=7 gives index 0
  // first priority after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      ptr_reg       <= IDX_W'(NUM_REQ - 1);
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  // Next-state logic: acquire from IDLE, hand over on release, preempt at the
  // hold limit only when someone else is waiting.
  always_comb begin
    state_next     = state_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_all.found) begin
          state_next     = GRANT;
          gnt_idx_next   = pick_all.idx;
          gnt_valid_next = 1'b1;
          ptr_next       = pick_all.idx;
          hold_cnt_next  = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_reg]) begin
          // Holder released: pass directly to the next requester, or go idle.
          if (pick_oth.found) begin
            gnt_idx_next  = pick_oth.idx;
            ptr_next      = pick_oth.idx;
            hold_cnt_next = '0;
          end else begin
            state_next     = IDLE;
            gnt_valid_next = 1'b0;
          end
        end else if (hold_cnt_reg == HOLD_LAST && pick_oth.found) begin
          // Contended holder has used its full window.
          gnt_idx_next  = pick_oth.idx;
          ptr_next      = pick_oth.idx;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_valid_next = 1'b0;
      end
    endcase
  end

  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;

  decoder3x8 u_gnt_dec (
    .in  (gnt_idx_reg),
    .en  (gnt_valid_reg),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (MAX_HOLD=4): hand-derived expected
// grants are queued as each cycle's stimulus is driven and compared after
// the following clock edge.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       chk_idx;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // Drive one cycle of stimulus and queue what must be visible after the edge.
  task automatic cyc(input string tag, input logic [7:0] r, input logic rn, input logic [7:0] eg);
    exp_t e;
    @(negedge clk);
    req   = r;
    rst_n = rn;
    e.gnt     = eg;
    e.idx     = idx_of(eg);
    e.chk_idx = (eg != 8'h00) || !rn;
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: compare shortly after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
      check({e.tag, ".valid"}, 32'(gnt_valid), 32'(e.gnt != 8'h00));
      if (e.chk_idx) check({e.tag, ".idx"}, 32'(gnt_idx), 32'(e.idx));
      check({e.tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
      $display("cyc %-8s req=%02h rst_n=%0d gnt=%02h idx=%0d valid=%0d exp=%02h",
               e.tag, req, rst_n, gnt, gnt_idx, gnt_valid, e.gnt);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;

    // 1. Reset then a single request.
    cyc("rst", 8'h00, 1'b0, 8'h00);
    cyc("rst", 8'h00, 1'b0, 8'h00);
    cyc("idle", 8'h00, 1'b1, 8'h00);
    cyc("single", 8'h10, 1'b1, 8'h10);
    cyc("single", 8'h10, 1'b1, 8'h10);

    // 2. Rotation 0..7,0 from a fresh reset.
    cyc("rst", 8'h00, 1'b0, 8'h00);
    cyc("rr", 8'hFF, 1'b1, 8'h01);
    for (int k = 0; k < 8; k++) begin
      cyc("rr", 8'hFF & ~(8'h01 << k), 1'b1, 8'h01 << ((k + 1) % 8));
    end
    cyc("rr_rel", 8'h00, 1'b1, 8'h00);

    // 3. Hold limit (MAX_HOLD=4): 4 cycles each, no idle gap.
    cyc("rst", 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      cyc("hold", 8'h03, 1'b1, (k / 4 == 1) ? 8'h02 : 8'h01);
    end
    // Holder drops on the same edge it reaches the limit: plain handover.
    cyc("simul", 8'h02, 1'b1, 8'h02);
    cyc("rel", 8'h00, 1'b1, 8'h00);

    // 4. Uncontended lock survives the hold limit.
    for (int k = 0; k < 40; k++) cyc("lock", 8'h20, 1'b1, 8'h20);
    cyc("lock_rel", 8'h00, 1'b1, 8'h00);

    // 5. Wrap from index 6 to 0, then reset mid-grant.
    cyc("wrap", 8'h40, 1'b1, 8'h40);
    cyc("wrap", 8'h41, 1'b1, 8'h40);
    cyc("wrap", 8'h01, 1'b1, 8'h01);
    cyc("wrap", 8'h01, 1'b1, 8'h01);
    cyc("midrst", 8'h01, 1'b0, 8'h00);
    cyc("post", 8'h81, 1'b1, 8'h01);
    cyc("post", 8'h81, 1'b1, 8'h01);
    cyc("post", 8'h80, 1'b1, 8'h80);
    cyc("post", 8'h00, 1'b1, 8'h00);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among eight requesters. It drives the existing 3-to-8 decoder: a registered 3-bit grant index plus a grant-valid enable are expanded into a one-hot grant bus. The arbiter adds grant locking (the holder keeps the grant while its request stays high) and a bounded hold time, so no requester can starve the others. It sits between the requester bank and the shared datapath select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while other requests are pending. Legal range is 2..256.
- `clk`  in  1: the single clock; everything is on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  in  8: request lines, one per requester. Bit i is requester i. Level-sensitive.
- `gnt`  out  8: one-hot grant, or all-zero when idle.
- `gnt_idx`  out  3: binary index of the current holder. Registered.
- `gnt_valid`  out  1: a grant is active. Registered.

## Operation
- State machine with two states, `IDLE` and `GRANT`.
- Internal `ptr[2:0]` holds the last granted index.
- Internal `hold_cnt` counts cycles since the current grant started. Its width is clog2(MAX_HOLD).
- **Winner selection:** the first set bit of `req` scanning ptr+1, ptr+2, … wrapping mod 8. The current holder is excluded when rotating.
- **IDLE:**
  - If `req != 0`: select the winner, load `gnt_idx`, set `gnt_valid=1`, set `ptr` to the winner, set `hold_cnt=0`, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, holder's request dropped** (`req[gnt_idx]==0`):
  - If any other request is set: hand over directly to the next winner in the same edge, with no idle gap, and clear `hold_cnt`.
  - Otherwise clear `gnt_valid` and go to IDLE.
- **GRANT, holder's request high:**
  - If `hold_cnt == MAX_HOLD-1` and another request is pending: preempt to the next winner and clear `hold_cnt`.
  - Otherwise keep the grant. `hold_cnt` increments and saturates at MAX_HOLD-1.
  - An uncontended holder therefore keeps the grant indefinitely.
- **Grant decode:** `gnt` is `gnt_idx` decoded with `gnt_valid` as the enable. It is combinational from registers only, with no `req`-to-`gnt` combinational path.
- **Invariant:** `gnt` has at most one bit set. When `gnt_valid=1`, `gnt == 1<<gnt_idx`.
- **Requests that appear mid-grant:** they are only considered at the next handover or preemption point.
- **Reset:** reset takes priority over all other activity, including in the middle of a grant. It sets state=IDLE, `gnt=0`, `gnt_idx=0`, `gnt_valid=0`, `ptr=7` (so index 0 has first priority), `hold_cnt=0`.

## Timing
- **Latency:** `req` rising in IDLE at edge N produces `gnt` valid after edge N+1. Arbitration is one cycle.
- **Handover:** the holder drops `req` before edge N. The new `gnt` is visible after edge N, and the old holder's bit clears on the same edge.
- **Release with no other requests:** `gnt` goes to 0 after the edge that samples the drop.
- **Contended hold:** the holder sees at most MAX_HOLD cycles of `gnt` high.
- **Wrap-around:** with `ptr=7`, the scan order is 0,1,…,6. With `ptr=5`, the scan order is 6,7,0,…,4.
- **Simultaneous events:** the holder dropping its request and reaching `hold_cnt` limit on the same edge are treated as a normal handover.

## Structure
- Shared package `arb_pkg`:
  - `NUM_REQ=8`, `IDX_W=3`.
  - State enum `{IDLE, GRANT}`.
  - Function `rr_pick(req, ptr)` returns the index and a found flag.
- One sub-module, `decoder3x8`, with ports (in[2:0], out[7:0], en). Instantiate it once for the grant decode.
- Keep the winner-select logic in the package function, not in a separate module.

## Test plan
1. Reset and single request:
   - Hold `rst_n=0` for 2 cycles, then release with `req=8'h00` → `gnt=0`, `gnt_valid=0`, `gnt_idx=0`.
   - Then `req=8'h10` → after 1 edge `gnt=8'h10`, `gnt_idx=4`.
2. Round-robin rotation:
   - `req=8'hFF`, each holder drops its request for 1 cycle after being granted, then reasserts.
   - Grant order must be 0,1,2,…,7,0, and each grant must be one-hot.
3. Hold limit with MAX_HOLD=4:
   - `req=8'h03` held constantly.
   - Expected: `gnt=01` for 4 cycles, `02` for 4 cycles, `01` again, with no idle cycle between.
4. Uncontended lock:
   - `req=8'h20` for 40 cycles → `gnt=8'h20` throughout, with no drop at the hold limit.
   - Then `req=0` → `gnt=0` after 1 edge.
5. Wrap-around and reset mid-grant:
   - Grant index 6, then `req=8'h41` with bit 6 dropping → next grant is index 0.
   - Assert `rst_n=0` while granted → `gnt=0` after that edge.
   - After release, `req=8'h81` grants 0 first (`ptr=7`).
